cond_unit: RTL

//   Conditional-execution unit for the multicycle ARM core.

---
 rtl/cond_unit.sv | 81 ++++++++
 1 files changed

// File: rtl/cond_unit.sv
// Conditional-execution unit for the multicycle ARM core.
// Holds the NZCV flag register, evaluates the instruction condition field
// against it, and gates the control FSM's PC/register/memory write strobes.
module cond_unit #(
    parameter bit COND_REG = 1'b1  // 1: gate with CondEx delayed one cycle (execute -> writeback)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       ALUOp,
    input  logic       PCS,
    input  logic       NextPC,
    input  logic       RegW,
    input  logic       MemW,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [3:0] Flags,
    output logic       CondEx
);

    logic [3:0] flags_q;
    logic       cond_ex_c;
    logic       cond_ex_q;
    logic       n, z, c, v;

    assign {n, z, c, v} = flags_q;

    // Evaluate the condition code against the stored flags (never ALUFlags)
    always_comb begin
        cond_ex_c = 1'b0;
        unique case (Cond)
            4'h0: cond_ex_c = z;
            4'h1: cond_ex_c = ~z;
            4'h2: cond_ex_c = c;
            4'h3: cond_ex_c = ~c;
            4'h4: cond_ex_c = n;
            4'h5: cond_ex_c = ~n;
            4'h6: cond_ex_c = v;
            4'h7: cond_ex_c = ~v;
            4'h8: cond_ex_c = c & ~z;
            4'h9: cond_ex_c = ~c | z;
            4'hA: cond_ex_c = (n == v);
            4'hB: cond_ex_c = (n != v);
            4'hC: cond_ex_c = ~z & (n == v);
            4'hD: cond_ex_c = z | (n != v);
            4'hE: cond_ex_c = 1'b1;
            4'hF: cond_ex_c = 1'b0;   // reserved encoding never executes
            default: cond_ex_c = 1'b0;
        endcase
    end

    // Flag register: N,Z and C,V halves load independently on a passing ALU op
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else if (ALUOp && cond_ex_c) begin
            if (FlagW[1]) flags_q[3:2] <= ALUFlags[3:2];
            if (FlagW[0]) flags_q[1:0] <= ALUFlags[1:0];
        end
    end

    // Carry the execute-state evaluation into the writeback state
    always_ff @(posedge clk) begin
        if (reset) cond_ex_q <= 1'b0;
        else       cond_ex_q <= cond_ex_c;
    end

    // Select gating source and gate the FSM strobes
    always_comb begin
        CondEx   = COND_REG ? cond_ex_q : cond_ex_c;
        PCWrite  = NextPC | (PCS & CondEx);
        RegWrite = RegW & CondEx;
        MemWrite = MemW & CondEx;
    end

    assign Flags = flags_q;

endmodule
